// File: rtl/iiitb_cps_param.sv
// Parametrised car-parking gate controller: password entry, retry lockout and occupancy tracking.
// Optional macro CPS_TIMEOUT_EN: RIGHT_PASS returns to IDLE after TIMEOUT_CYC cycles without an exit.
module iiitb_cps_param #(
    parameter int PW_W        = 2,
    parameter int PASS_1      = 1,
    parameter int PASS_2      = 2,
    parameter int WAIT_CYC    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYC    = 16,
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int BLINK_DIV   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             car_leave,
    input  logic [PW_W-1:0]  password_1,
    input  logic [PW_W-1:0]  password_2,
    input  logic             pass_valid,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [6:0]       HEX_1,
    output logic [6:0]       HEX_2,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             locked
);

    localparam int WAIT_W  = (WAIT_CYC  > 1) ? $clog2(WAIT_CYC)  : 1;
    localparam int LOCK_W  = (LOCK_CYC  > 1) ? $clog2(LOCK_CYC)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [6:0] HEX_OFF = 7'h7F;
    localparam logic [6:0] HEX_E   = 7'h06;
    localparam logic [6:0] HEX_N   = 7'h2B;
    localparam logic [6:0] HEX_6   = 7'h02;
    localparam logic [6:0] HEX_0   = 7'h40;
    localparam logic [6:0] HEX_S   = 7'h12;
    localparam logic [6:0] HEX_P   = 7'h0C;
    localparam logic [6:0] HEX_L   = 7'h47;
    localparam logic [6:0] HEX_F   = 7'h0E;
    localparam logic [6:0] HEX_U   = 7'h41;

    if (((1 << CNT_W) <= CAPACITY) || (WAIT_CYC < 1) || (MAX_TRIES < 1) ||
        (BLINK_DIV < 1) || (LOCK_CYC < 1) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("iiitb_cps_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        STOP          = 3'd4,
        LOCKOUT       = 3'd5
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_on;
    logic [TRY_W-1:0]    tries;
    logic [TRY_W:0]      tries_inc;
    logic                match;
    logic                car_in;
    logic                timed_out;

    assign match     = (password_1 == PW_W'(PASS_1)) && (password_2 == PW_W'(PASS_2));
    assign full      = (occupancy == CNT_W'(CAPACITY));
    assign tries_inc = {1'b0, tries} + (TRY_W+1)'(1);
    assign car_in    = (state == RIGHT_PASS) && sensor_exit && !sensor_entrance;

`ifdef CPS_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] dwell_cnt;

    assign timed_out = (dwell_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Dwell timer restarts from zero on every entry into RIGHT_PASS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dwell_cnt <= '0;
        else if (state == RIGHT_PASS && next_state == RIGHT_PASS)
            dwell_cnt <= dwell_cnt + TO_W'(1);
        else
            dwell_cnt <= '0;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:
                if (sensor_entrance && !full) next_state = WAIT_PASSWORD;
            WAIT_PASSWORD:
                if (wait_cnt == WAIT_W'(WAIT_CYC - 1)) next_state = match ? RIGHT_PASS : WRONG_PASS;
            WRONG_PASS:
                if (pass_valid) begin
                    if (match)
                        next_state = RIGHT_PASS;
                    else if (tries_inc >= (TRY_W+1)'(MAX_TRIES))
                        next_state = LOCKOUT;
                end
            RIGHT_PASS:
                if (sensor_entrance && sensor_exit) next_state = STOP;
                else if (sensor_exit)               next_state = IDLE;
                else if (timed_out)                 next_state = IDLE;
            STOP:
                if (pass_valid && match) next_state = RIGHT_PASS;
            LOCKOUT:
                if (lock_cnt == LOCK_W'(LOCK_CYC - 1)) next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    // Outputs decode the current state, so they trail a state change by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lock_cnt  <= '0;
            tries     <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            occupancy <= '0;
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            HEX_1     <= HEX_OFF;
            HEX_2     <= HEX_OFF;
            locked    <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == WAIT_PASSWORD && next_state == WAIT_PASSWORD) ? wait_cnt + WAIT_W'(1) : '0;
            lock_cnt <= (state == LOCKOUT && next_state == LOCKOUT) ? lock_cnt + LOCK_W'(1) : '0;

            if (state == WAIT_PASSWORD && next_state == WRONG_PASS)
                tries <= TRY_W'(1);
            else if (state == WRONG_PASS && pass_valid)
                tries <= match ? '0 : tries_inc[TRY_W-1:0];
            else if (state == LOCKOUT && next_state == IDLE)
                tries <= '0;

            // Blink phase restarts lit on every state entry.
            if (next_state != state) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            if (car_in && !car_leave) begin
                if (!full) occupancy <= occupancy + CNT_W'(1);
            end else if (car_leave && !car_in) begin
                if (occupancy != '0) occupancy <= occupancy - CNT_W'(1);
            end

            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            locked    <= 1'b0;
            HEX_1     <= HEX_OFF;
            HEX_2     <= HEX_OFF;
            case (state)
                IDLE:
                    if (full) begin
                        HEX_1 <= HEX_F;
                        HEX_2 <= HEX_U;
                    end
                WAIT_PASSWORD: begin
                    RED_LED <= 1'b1;
                    HEX_1   <= HEX_E;
                    HEX_2   <= HEX_N;
                end
                WRONG_PASS: begin
                    RED_LED <= blink_on;
                    HEX_1   <= HEX_E;
                    HEX_2   <= HEX_E;
                end
                RIGHT_PASS: begin
                    GREEN_LED <= blink_on;
                    HEX_1     <= HEX_6;
                    HEX_2     <= HEX_0;
                end
                STOP: begin
                    RED_LED <= blink_on;
                    HEX_1   <= HEX_S;
                    HEX_2   <= HEX_P;
                end
                LOCKOUT: begin
                    RED_LED <= 1'b1;
                    locked  <= 1'b1;
                    HEX_1   <= HEX_L;
                    HEX_2   <= HEX_0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iiitb_cps_param.sv
// Scoreboard bench for iiitb_cps_param: directed stimulus queues expected outputs, a negedge monitor compares.
// The RIGHT_PASS timeout scenario runs only when CPS_TIMEOUT_EN is defined.
module tb_iiitb_cps_param;

    localparam logic [6:0] HEX_OFF = 7'h7F;
    localparam logic [6:0] HEX_E   = 7'h06;
    localparam logic [6:0] HEX_N   = 7'h2B;
    localparam logic [6:0] HEX_6   = 7'h02;
    localparam logic [6:0] HEX_0   = 7'h40;
    localparam logic [6:0] HEX_S   = 7'h12;
    localparam logic [6:0] HEX_P   = 7'h0C;
    localparam logic [6:0] HEX_L   = 7'h47;
    localparam logic [6:0] HEX_F   = 7'h0E;
    localparam logic [6:0] HEX_U   = 7'h41;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic       car_leave;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pass_valid;
    logic       GREEN_LED;
    logic       RED_LED;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;
    logic [3:0] occupancy;
    logic       full;
    logic       locked;

    typedef struct packed {
        logic       green;
        logic       red;
        logic [6:0] hex1;
        logic [6:0] hex2;
        logic [3:0] occ;
        logic       full;
        logic       locked;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    iiitb_cps_param dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .car_leave       (car_leave),
        .password_1      (password_1),
        .password_2      (password_2),
        .pass_valid      (pass_valid),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .HEX_1           (HEX_1),
        .HEX_2           (HEX_2),
        .occupancy       (occupancy),
        .full            (full),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle, so every queued expectation is retired at the falling edge.
    always @(negedge clk) begin : monitor
        obs_t  act;
        obs_t  exp_v;
        string nm;
        act = {GREEN_LED, RED_LED, HEX_1, HEX_2, occupancy, full, locked};
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            n_total++;
            if (act === exp_v)
                n_pass++;
            else
                $display("[TB] FAIL %s: got g=%b r=%b hex=%h/%h occ=%0d full=%b locked=%b, expected g=%b r=%b hex=%h/%h occ=%0d full=%b locked=%b",
                         nm, act.green, act.red, act.hex1, act.hex2, act.occ, act.full, act.locked,
                         exp_v.green, exp_v.red, exp_v.hex1, exp_v.hex2, exp_v.occ, exp_v.full, exp_v.locked);
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int se, input int sx, input int cl,
                                  input int p1, input int p2, input int pv);
        sensor_entrance = se[0];
        sensor_exit     = sx[0];
        car_leave       = cl[0];
        password_1      = 2'(p1);
        password_2      = 2'(p2);
        pass_valid      = pv[0];
    endtask

    task automatic check_output(input string nm, input int g, input int r,
                                input logic [6:0] h1, input logic [6:0] h2,
                                input int occ, input int f, input int lk);
        obs_t e;
        e = {1'(g), 1'(r), h1, h2, 4'(occ), 1'(f), 1'(lk)};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Admits one car with the right password; checks the IDLE display afterwards.
    task automatic admit_car(input int exp_occ);
        apply_stimulus(1, 0, 0, 1, 2, 0); step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0); step(4);
        apply_stimulus(0, 1, 0, 1, 2, 0); step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0); step(1);
        check_output("admit_car", 0, 0, (exp_occ == 8) ? HEX_F : HEX_OFF,
                     (exp_occ == 8) ? HEX_U : HEX_OFF, exp_occ, int'(exp_occ == 8), 0);
    endtask

    initial begin : stimulus
        reset_n = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("reset_values", 0, 0, HEX_OFF, HEX_OFF, 0, 0, 0);
        step(2);
        reset_n = 1'b1;
        step(1);

        $display("[TB] correct password");
        apply_stimulus(1, 0, 0, 1, 2, 0);
        step(1);
        check_output("t1_idle_lag", 0, 0, HEX_OFF, HEX_OFF, 0, 0, 0);
        step(1);
        check_output("t1_wait", 0, 1, HEX_E, HEX_N, 0, 0, 0);
        step(3);
        check_output("t1_wait_last", 0, 1, HEX_E, HEX_N, 0, 0, 0);
        step(1);
        check_output("t1_right", 1, 0, HEX_6, HEX_0, 0, 0, 0);
        step(2);
        check_output("t1_green_off", 0, 0, HEX_6, HEX_0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 1, 2, 0);
        step(1);
        check_output("t1_exit_count", 0, 0, HEX_6, HEX_0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t1_idle", 0, 0, HEX_OFF, HEX_OFF, 1, 0, 0);

        $display("[TB] wrong then right");
        apply_stimulus(1, 0, 0, 0, 0, 0);
        step(1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step(4);
        check_output("t2_wait_end", 0, 1, HEX_E, HEX_N, 1, 0, 0);
        step(1);
        check_output("t2_wrong", 0, 1, HEX_E, HEX_E, 1, 0, 0);
        step(2);
        check_output("t2_red_off", 0, 0, HEX_E, HEX_E, 1, 0, 0);
        step(2);
        check_output("t2_red_on", 0, 1, HEX_E, HEX_E, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 2, 1);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t2_right", 1, 0, HEX_6, HEX_0, 1, 0, 0);
        apply_stimulus(0, 1, 0, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t2_idle", 0, 0, HEX_OFF, HEX_OFF, 2, 0, 0);

        $display("[TB] lockout");
        apply_stimulus(1, 0, 0, 0, 0, 0);
        step(1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step(4);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        step(2);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t3_locked", 0, 1, HEX_L, HEX_0, 2, 0, 1);
        apply_stimulus(1, 0, 0, 1, 2, 1);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t3_ignore_valid", 0, 1, HEX_L, HEX_0, 2, 0, 1);
        apply_stimulus(0, 0, 1, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t3_leave_in_lock", 0, 1, HEX_L, HEX_0, 1, 0, 1);
        step(11);
        check_output("t3_last_lock_cycle", 0, 1, HEX_L, HEX_0, 1, 0, 1);
        step(1);
        check_output("t3_unlocked", 0, 0, HEX_OFF, HEX_OFF, 1, 0, 0);

        $display("[TB] tailgate and simultaneous events");
        apply_stimulus(1, 0, 0, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(4);
        apply_stimulus(1, 1, 0, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step(1);
        check_output("t5_stop", 0, 1, HEX_S, HEX_P, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        step(1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step(1);
        check_output("t5_stop_miss", 0, 0, HEX_S, HEX_P, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 2, 1);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t5_right_again", 1, 0, HEX_6, HEX_0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t5_exit_with_leave", 0, 0, HEX_OFF, HEX_OFF, 1, 0, 0);

        $display("[TB] capacity");
        for (int i = 2; i <= 8; i++) admit_car(i);
        apply_stimulus(1, 0, 0, 1, 2, 0);
        step(6);
        check_output("t4_full_stays_idle", 0, 0, HEX_F, HEX_U, 8, 1, 0);
        apply_stimulus(0, 0, 1, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(1);
        check_output("t4_leave_from_full", 0, 0, HEX_OFF, HEX_OFF, 7, 0, 0);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 1, 1, 2, 0);
            step(1);
            apply_stimulus(0, 0, 0, 1, 2, 0);
            step(1);
        end
        check_output("t4_leave_at_zero", 0, 0, HEX_OFF, HEX_OFF, 0, 0, 0);

        $display("[TB] asynchronous reset mid-sequence");
        for (int i = 1; i <= 3; i++) admit_car(i);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        step(1);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        step(1);
        check_output("t6_wait", 0, 1, HEX_E, HEX_N, 3, 0, 0);
        step(1);
        reset_n = 1'b0;
        #1;
        check_output("t6_async_reset", 0, 0, HEX_OFF, HEX_OFF, 0, 0, 0);
        step(1);
        reset_n = 1'b1;
        step(1);
        check_output("t6_after_reset", 0, 0, HEX_OFF, HEX_OFF, 0, 0, 0);

`ifdef CPS_TIMEOUT_EN
        $display("[TB] RIGHT_PASS timeout");
        apply_stimulus(1, 0, 0, 1, 2, 0);
        step(1);
        apply_stimulus(0, 0, 0, 1, 2, 0);
        step(4);
        step(64);
        check_output("to_last_right", 0, 0, HEX_6, HEX_0, 0, 0, 0);
        step(1);
        check_output("to_idle", 0, 0, HEX_OFF, HEX_OFF, 0, 0, 0);
`endif

        step(2);
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL drain: %0d expectations left unsampled, expected 0", exp_q.size());
            n_total += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iiitb_cps_param.md
Name: iiitb_cps_param

Overview:
Parametrised next-generation car-parking gate controller. It replaces the fixed 2-bit, single-slot password FSM with the following:
- configurable password width, codes and wait time
- bounded retry count with a timed lockout
- an occupancy counter with a capacity limit
Sits behind the user-project wrapper; sensors, passwords and strobes come from IO/LA, and LEDs, 7-segment codes and status go back out.

Parameters:
PW_W, 2, width of each password field
PASS_1, 1, required value of password_1 (PW_W bits)
PASS_2, 2, required value of password_2 (PW_W bits)
WAIT_CYC, 4, cycles spent in WAIT_PASSWORD before first compare (>=1)
MAX_TRIES, 3, wrong attempts that trigger LOCKOUT (>=1)
LOCK_CYC, 16, LOCKOUT duration in cycles
CAPACITY, 8, parking slots
CNT_W, 4, occupancy width; must satisfy 2**CNT_W > CAPACITY
BLINK_DIV, 2, cycles between blinking-LED toggles (>=1)
TIMEOUT_CYC, 64, RIGHT_PASS timeout (used only with optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sensor_entrance  input  1  car present at entry gate (level)
sensor_exit  input  1  car passed entry gate (level)
car_leave  input  1  one-cycle pulse: a car left the lot
password_1  input  PW_W  first password field
password_2  input  PW_W  second password field
pass_valid  input  1  one-cycle strobe: retry attempt in WRONG_PASS/STOP
GREEN_LED  output  1  gate-open indicator
RED_LED  output  1  wait/error indicator
HEX_1  output  7  7-seg left digit, active-low segments {g..a}
HEX_2  output  7  7-seg right digit
occupancy  output  CNT_W  cars currently parked
full  output  1  occupancy == CAPACITY
locked  output  1  high while in LOCKOUT

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; every flop is cleared on reset_n low.
- Reset values: state IDLE; tries, occupancy and all counters 0; GREEN_LED/RED_LED 0; HEX_1/HEX_2 7'h7F; full 0; locked 0.
- Reset mid-operation aborts any sequence; occupancy is also cleared.
- State encoding: 3 bits, with states IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, LOCKOUT. Unused encodings go to IDLE.
- Password match: (password_1==PASS_1)&&(password_2==PASS_2).
- IDLE:
  - sensor_entrance=1 and !full -> WAIT_PASSWORD.
  - sensor_entrance=1 and full -> stay IDLE; display "FU".
- WAIT_PASSWORD:
  - wait counter increments each cycle.
  - On the cycle the count reaches WAIT_CYC-1: match -> RIGHT_PASS; else -> WRONG_PASS with tries=1.
- WRONG_PASS: evaluated only on pass_valid.
  - match -> RIGHT_PASS, tries cleared.
  - miss -> tries+1; if the new value == MAX_TRIES -> LOCKOUT, else stay.
- RIGHT_PASS:
  - sensor_entrance && sensor_exit (tailgate) -> STOP.
  - else sensor_exit -> IDLE with occupancy+1.
  - else stay.
- STOP: pass_valid && match -> RIGHT_PASS. A miss is ignored; STOP does not count tries.
- LOCKOUT:
  - locked=1; all inputs except car_leave are ignored.
  - After LOCK_CYC cycles -> IDLE, tries cleared.
- Occupancy:
  - +1 on RIGHT_PASS->IDLE; -1 on car_leave.
  - Both in the same cycle -> unchanged.
  - Saturates at 0 (car_leave at 0 is ignored) and at CAPACITY.
  - full is combinational from occupancy.
- Outputs are registered from current_state: they change 1 cycle after the state changes.
  - IDLE: LEDs off; HEX off (or "FU" = 7'h0E,7'h41 when full).
  - WAIT_PASSWORD: red on; "En" = 7'h06,7'h2B.
  - WRONG_PASS: red blinks; "EE" = 7'h06,7'h06.
  - RIGHT_PASS: green blinks; "60" = 7'h02,7'h40.
  - STOP: red blinks; "SP" = 7'h12,7'h0C.
  - LOCKOUT: red steady; "LO" = 7'h47,7'h40.
- Blinking: a free-running divider toggles the LED every BLINK_DIV cycles while in the blink state. The LED starts at 1 on state entry.

Optional Feature:
CPS_TIMEOUT_EN:
- Defined: a RIGHT_PASS dwell counter runs. If TIMEOUT_CYC cycles elapse with no sensor_exit, go to IDLE with occupancy unchanged. The counter restarts on every RIGHT_PASS entry.
- Undefined: RIGHT_PASS waits indefinitely and TIMEOUT_CYC is unused.

Test Plan:
1. Correct password: reset, sensor_entrance=1, pw=(1,2) held -> WAIT_PASSWORD for 4 cycles, then RIGHT_PASS, HEX=7'h02/7'h40. sensor_exit=1 -> IDLE, occupancy=1.
2. Wrong then right: pw=(0,0) -> WRONG_PASS, HEX "EE", red toggling every 2 cycles. Then pw=(1,2)+pass_valid -> RIGHT_PASS, tries=0.
3. Lockout: wrong at WAIT_PASSWORD plus 2 wrong pass_valid -> locked=1, HEX "LO". After 16 cycles -> IDLE, locked=0. A correct pass_valid during LOCKOUT is ignored.
4. Capacity: admit 8 cars -> full=1. Sensor_entrance stays IDLE showing "FU". car_leave -> occupancy=7, full=0. car_leave at 0 keeps 0.
5. Tailgate plus simultaneous events: in RIGHT_PASS assert both sensors -> STOP, "SP". Correct pass_valid -> RIGHT_PASS. Exit while car_leave pulses -> occupancy unchanged.
6. Reset mid-WAIT_PASSWORD with occupancy=3 -> all outputs at reset values immediately (async), occupancy=0. With CPS_TIMEOUT_EN: RIGHT_PASS idle 64 cycles -> IDLE.
